// File: rtl/rr_enc_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_enc_arbiter : 8-way round-robin arbiter (rotate, encode, decode) with  |
// |                  registered, held grant. Optional forced release under    |
// |                  macro ARB_TIMEOUT_EN.                                    |
// | Revision       : 1.0 - initial release                                    |
// +--------------------------------------------------------------------------+
module rr_enc_arbiter #(
    parameter int N        = 8,
    parameter int IDW      = 3,
    parameter int HOLD_MAX = 15
) (
    input  logic           Clk,
    input  logic           Rst_n,
    input  logic [N-1:0]   Req,
    output logic [N-1:0]   Grant,
    output logic [IDW-1:0] GrantId,
    output logic           GrantValid,
    output logic           Timeout
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // The encoder/decoder pair is fixed at 8 ways.
    if (N != 8 || IDW != 3 || HOLD_MAX < 2) begin : g_param_check
        $error("rr_enc_arbiter: requires N=8, IDW=3, HOLD_MAX>=2");
    end

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [N-1:0]   grant_q, grant_d;
    logic           grant_valid_q, grant_valid_d;

    logic [2*N-1:0] w_req_dbl;
    logic [N-1:0]   w_rot;
    logic [IDW-1:0] w_enc;
    logic [IDW-1:0] w_win;
    logic           w_owner_req;
    logic           w_force_rel;

    assign w_req_dbl   = {Req, Req};
    assign w_rot       = w_req_dbl[ptr_q +: N];
    assign w_win       = w_enc + ptr_q;
    assign w_owner_req = Req[grant_id_q];

    // Priority encoder: lowest set bit of the rotated vector.
    always_comb begin
        w_enc = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_enc = IDW'(i);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int HCW = $clog2(HOLD_MAX + 1);

    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic           timeout_q, timeout_d;

    assign w_force_rel = (state_q == ST_GRANT) && w_owner_req &&
                         (hold_cnt_q == HCW'(HOLD_MAX - 1));

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (|Req) begin
                hold_cnt_d = '0;
            end
        end else if (w_force_rel) begin
            timeout_d = 1'b1;
        end else if (w_owner_req && (hold_cnt_q != {HCW{1'b1}})) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign Timeout = timeout_q;
`else
    assign w_force_rel = 1'b0;
    assign Timeout     = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_id_d    = grant_id_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (|Req) begin
                    state_d       = ST_GRANT;
                    grant_id_d    = w_win;
                    grant_d       = {{(N-1){1'b0}}, 1'b1} << w_win;
                    grant_valid_d = 1'b1;
                end
            end
            ST_GRANT: begin
                // Only the owner's request matters here; others never preempt.
                if (!w_owner_req || w_force_rel) begin
                    state_d       = ST_IDLE;
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    ptr_d         = grant_id_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            grant_id_q    <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_id_q    <= grant_id_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
        end
    end

    assign Grant      = grant_q;
    assign GrantId    = grant_id_q;
    assign GrantValid = grant_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_enc_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rr_enc_arbiter : scoreboard bench for rr_enc_arbiter                  |
// | Revision          : 1.0 - initial release                                 |
// +--------------------------------------------------------------------------+
module tb_rr_enc_arbiter;

    logic       Clk;
    logic       Rst_n;
    logic [7:0] Req;
    logic [7:0] Grant;
    logic [2:0] GrantId;
    logic       GrantValid;
    logic       Timeout;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    rr_enc_arbiter #(.N(8), .IDW(3), .HOLD_MAX(15)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Req        (Req),
        .Grant      (Grant),
        .GrantId    (GrantId),
        .GrantValid (GrantValid),
        .Timeout    (Timeout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every new grant is checked against the next queued owner.
    initial begin : monitor
        logic prev_v;
        int   e;
        prev_v = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            chk("valid_eq_or_grant", 32'(GrantValid), 32'(|Grant));
            chk("grant_onehot0", 32'($onehot0(Grant)), 32'd1);
            if (GrantValid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_grant: actual id %0d required none", GrantId);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant_id", 32'(GrantId), 32'(e));
                    chk("grant_vec", 32'(Grant), 32'(8'd1 << e));
                end
            end
            prev_v = GrantValid;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // Drive req, expect owner exp_id after one clock, hold, then release.
    task automatic grant_cycle(input logic [7:0] req, input int exp_id, input int hold);
        @(negedge Clk);
        Req = req;
        exp_q.push_back(exp_id);
        @(posedge Clk);
        #1;
        chk("req_to_grant_latency", 32'(GrantValid), 32'd1);
        repeat (hold) @(posedge Clk);
        @(negedge Clk);
        Req = 8'h00;
        @(posedge Clk);
        #1;
        chk("release_valid", 32'(GrantValid), 32'd0);
        chk("grant_id_kept", 32'(GrantId), 32'(exp_id));
    endtask

    initial begin : stim
        int         held;
        bit         tout_seen;
        logic [7:0] drop;

        Req   = 8'h00;
        Rst_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_grant", 32'(Grant), 32'd0);
        chk("rst_grant_id", 32'(GrantId), 32'd0);
        chk("rst_valid", 32'(GrantValid), 32'd0);
        chk("rst_timeout", 32'(Timeout), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Single requester 4, then ptr=5 makes 5 beat 4, then wrap from 6.
        grant_cycle(8'h10, 4, 3);
        grant_cycle(8'h30, 5, 1);
        grant_cycle(8'h21, 0, 1);

        // No preemption: owner 3 keeps its grant while others request.
        @(negedge Clk);
        Req = 8'h08;
        exp_q.push_back(3);
        @(negedge Clk);
        Req = 8'h0F;
        repeat (5) begin
            @(posedge Clk);
            #1;
            chk("no_preempt_grant", 32'(Grant), 32'h08);
        end
        @(negedge Clk);
        Req = 8'h07;
        exp_q.push_back(0);
        @(posedge Clk);
        #1;
        chk("no_preempt_dead", 32'(GrantValid), 32'd0);
        @(posedge Clk);
        #1;
        chk("after_preempt_grant", 32'(Grant), 32'h01);
        @(negedge Clk);
        Req = 8'h00;
        @(posedge Clk);

        // Async reset mid-grant (ptr=1, owner 2).
        @(negedge Clk);
        Req = 8'h04;
        exp_q.push_back(2);
        @(posedge Clk);
        #1;
        chk("pre_reset_grant", 32'(Grant), 32'h04);
        @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        chk("mid_reset_grant", 32'(Grant), 32'd0);
        chk("mid_reset_valid", 32'(GrantValid), 32'd0);
        Req = 8'h00;
        @(negedge Clk);
        Rst_n = 1'b1;
        grant_cycle(8'h80, 7, 0);

        // Fairness from ptr=0 with all requesting.
        @(negedge Clk);
        Req = 8'hFF;
        for (int k = 0; k < 9; k++) exp_q.push_back(k % 8);
        for (int k = 0; k < 9; k++) begin
            @(posedge Clk);
            #1;
            chk("fair_valid", 32'(GrantValid), 32'd1);
            if (k < 8) begin
                drop = 8'd1 << k;
                @(negedge Clk);
                Req = 8'hFF & ~drop;
                @(posedge Clk);
                #1;
                chk("fair_dead_cycle", 32'(GrantValid), 32'd0);
                @(negedge Clk);
                Req = 8'hFF;
            end
        end
        @(negedge Clk);
        Req = 8'h00;
        @(posedge Clk);

        // Back to ptr=0 for the hold / timeout check.
        @(negedge Clk);
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        Req = 8'h03;
        exp_q.push_back(0);
        held      = 0;
        tout_seen = 1'b0;
        @(posedge Clk);
        #1;
        if (GrantValid && Grant == 8'h01) held = 1;
`ifdef ARB_TIMEOUT_EN
        exp_q.push_back(1);
        for (int i = 0; i < 120; i++) begin
            @(posedge Clk);
            #1;
            if (!GrantValid) break;
            held++;
        end
        chk("timeout_tenure", 32'(held), 32'd15);
        chk("timeout_pulse", 32'(Timeout), 32'd1);
        @(posedge Clk);
        #1;
        chk("timeout_pulse_end", 32'(Timeout), 32'd0);
        chk("regrant_after_timeout", 32'(GrantId), 32'd1);
`else
        repeat (99) begin
            @(posedge Clk);
            #1;
            if (GrantValid && Grant == 8'h01) held++;
            if (Timeout) tout_seen = 1'b1;
        end
        chk("hold_100_cycles", 32'(held), 32'd100);
        chk("timeout_stays_0", 32'(tout_seen), 32'd0);
`endif
        @(negedge Clk);
        Req = 8'h00;
        @(posedge Clk);
        #1;
        chk("final_release", 32'(GrantValid), 32'd0);
        repeat (3) @(posedge Clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
